// File: rtl/audio_nios_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audio_nios_mem_pkg
// Purpose  : Shared constants and types for the on-chip RAM arbiter slice.
//            Holds the RAM geometry, the owner encoding used to route read
//            data back to a master, and the read tag carried for one cycle.
// Revision : 1.0 - initial release
// ============================================================================
package audio_nios_mem_pkg;

  localparam int          ADDR_W = 16;     // word address width
  localparam int          DATA_W = 32;     // data width
  localparam int          BE_W   = 4;      // byteenable width (DATA_W/8)
  localparam int          ERR_W  = 16;     // out-of-range counter width
  localparam int unsigned DEPTH  = 40000;  // words actually present in RAM

  // Which master owns an access / a returning read
  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  // Read tag: travels alongside the RAM's one-cycle read latency
  typedef struct packed {
    logic   valid;  // a read was accepted last cycle
    owner_e owner;  // which master receives readdatavalid
    logic   oor;    // address was out of range: return zero
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/audio_nios_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : audio_nios_rr_arb2
// Purpose  : Two-way round-robin arbiter with combinational grant.
// Ports    : clk, reset    - clock, synchronous active-high reset
//            req_i[1:0]    - request per master (bit0 = m0, bit1 = m1)
//            accept_i      - the granted command is really taken this cycle
//            grant_o[1:0]  - one-hot grant (all zero when nobody requests)
// Revision : 1.0 - initial release
// ============================================================================
module audio_nios_rr_arb2
  import audio_nios_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  owner_e last_q;
  owner_e last_d;

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      // Contention: whoever was not served most recently goes first
      2'b11:   grant_o = (last_q == OWN_M1) ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  // The pointer only moves when a command is actually consumed, so a
  // reset-blocked grant does not steal the loser's turn.
  always_comb begin
    last_d = last_q;
    if (accept_i && (grant_o != 2'b00)) begin
      last_d = grant_o[1] ? OWN_M1 : OWN_M0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= OWN_M1;  // m0 wins the first contention after reset
    end else begin
      last_q <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/audio_nios_onchip_memory2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : audio_nios_onchip_memory2_arbiter
// Purpose  : Shares the single-port 40000x32 program/data RAM between the
//            Nios II data master (m0) and the audio sample DMA (m1).
//            One access per cycle, round-robin under contention, read data
//            steered back to its owner one cycle after acceptance.
//            Out-of-range accesses complete harmlessly and are counted.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            m0_* / m1_*           - Avalon-MM slave ports per master
//            mem_*                 - RAM port (1-cycle read latency)
//            err_count             - saturating out-of-range access count
// Revision : 1.0 - initial release
// ============================================================================
module audio_nios_onchip_memory2_arbiter
  import audio_nios_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  // master 0 : Nios II data master
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  // master 1 : audio sample DMA
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  // RAM port
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  // status
  output logic [ERR_W-1:0]  err_count
);

  logic [1:0]        w_req;
  logic [1:0]        w_grant;
  logic              w_accept;
  logic              w_sel_m1;
  logic [ADDR_W-1:0] w_addr;
  logic              w_wr;
  logic              w_oor;
  logic [DATA_W-1:0] w_rdata;

  tag_t              tag_q;
  tag_t              tag_d;
  logic [ERR_W-1:0]  err_q;
  logic [ERR_W-1:0]  err_d;

  assign w_req = {m1_read | m1_write, m0_read | m0_write};

  audio_nios_rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req_i    (w_req),
    .accept_i (w_accept),
    .grant_o  (w_grant)
  );

  // Nothing is accepted while reset is held, even if a grant is computed
  assign w_accept = ~reset & (|w_grant);
  assign w_sel_m1 = w_grant[1];

  // Winner's command; a simultaneous read+write is a write
  assign w_addr = w_sel_m1 ? m1_address : m0_address;
  assign w_wr   = w_sel_m1 ? m1_write   : m0_write;
  assign w_oor  = 32'(w_addr) >= DEPTH;

  assign mem_address    = w_addr;
  assign mem_byteenable = w_sel_m1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = w_sel_m1 ? m1_writedata  : m0_writedata;
  assign mem_chipselect = w_accept & ~w_oor;
  assign mem_write      = w_accept & ~w_oor & w_wr;
  assign mem_clken      = ~reset;

  // Idle masters see waitrequest low; only the contention loser stalls
  assign m0_waitrequest = reset | (w_req[0] & ~w_grant[0]);
  assign m1_waitrequest = reset | (w_req[1] & ~w_grant[1]);

  always_comb begin
    tag_d       = '0;
    tag_d.valid = w_accept & ~w_wr;
    tag_d.owner = w_sel_m1 ? OWN_M1 : OWN_M0;
    tag_d.oor   = w_oor;
  end

  // Out-of-range reads never touched the RAM, so they return zero
  assign w_rdata = tag_q.oor ? '0 : mem_readdata;

  assign m0_readdata = w_rdata;
  assign m1_readdata = w_rdata;
  // Gated with reset so a read in flight when reset arrives is dropped
  assign m0_readdatavalid = ~reset & tag_q.valid & (tag_q.owner == OWN_M0);
  assign m1_readdatavalid = ~reset & tag_q.valid & (tag_q.owner == OWN_M1);

  always_comb begin
    err_d = err_q;
    if (w_accept && w_oor && !(&err_q)) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  assign err_count = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q <= '0;
      err_q <= '0;
    end else begin
      tag_q <= tag_d;
      err_q <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_audio_nios_onchip_memory2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_nios_onchip_memory2_arbiter
// Purpose  : Self-checking bench for the two-master RAM arbiter. Includes a
//            behavioural RAM with 1-cycle read latency and a transaction-
//            level reference model (served-last pointer, pending read,
//            shadow memory, saturating error count).
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_nios_onchip_memory2_arbiter;

  localparam int NWORDS = 40000;

  logic        clk;
  logic        reset;
  logic [15:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m1_read, m0_write, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [15:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic [15:0] err_count;

  audio_nios_onchip_memory2_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata),
    .err_count        (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // ---------------- behavioural RAM (address registered) ----------------
  logic [31:0] ram [0:NWORDS-1];
  logic [15:0] ram_addr_q = 16'd0;
  logic        ram_ready  = 1'b0;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < NWORDS; i++) ram[i] <= init_word(i);
      ram_ready <= 1'b1;
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end
      ram_addr_q <= mem_address;
    end
  end

  assign mem_readdata = (int'(ram_addr_q) < NWORDS) ? ram[ram_addr_q] : 32'h0;

  // ---------------- reference model ----------------
  logic [31:0] model_mem [0:NWORDS-1];
  int          served_last;   // master served most recently (0/1)
  bit          pend_v;
  int          pend_own;
  logic [31:0] pend_data;
  int          err_m;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic step(input bit rst,
                      input bit r0, input bit w0, input logic [15:0] a0,
                      input logic [3:0] be0, input logic [31:0] d0,
                      input bit r1, input bit w1, input logic [15:0] a1,
                      input logic [3:0] be1, input logic [31:0] d1);
    int          win;
    bit          wr, oor, cs;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    reset = rst;
    m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = d0;
    m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
    #3;
    win = -1;
    if (!rst) begin
      if ((r0 || w0) && (r1 || w1)) win = (served_last == 1) ? 0 : 1;
      else if (r0 || w0)            win = 0;
      else if (r1 || w1)            win = 1;
    end
    wr   = (win == 1) ? w1 : w0;
    addr = (win == 1) ? a1 : a0;
    be   = (win == 1) ? be1 : be0;
    wd   = (win == 1) ? d1 : d0;
    oor  = int'(addr) >= NWORDS;
    cs   = (win >= 0) && !oor;

    check_val("m0_waitrequest", 64'(m0_waitrequest), 64'(rst || ((r0 || w0) && win != 0)));
    check_val("m1_waitrequest", 64'(m1_waitrequest), 64'(rst || ((r1 || w1) && win != 1)));
    check_val("mem_chipselect", 64'(mem_chipselect), 64'(cs));
    check_val("mem_write",      64'(mem_write),      64'(cs && wr));
    check_val("mem_clken",      64'(mem_clken),      64'(!rst));
    check_val("m0_rdv", 64'(m0_readdatavalid), 64'(!rst && pend_v && pend_own == 0));
    check_val("m1_rdv", 64'(m1_readdatavalid), 64'(!rst && pend_v && pend_own == 1));
    check_val("err_count", 64'(err_count), 64'(err_m));
    if (cs) check_val("mem_address", 64'(mem_address), 64'(addr));
    if (cs && wr) begin
      check_val("mem_byteenable", 64'(mem_byteenable), 64'(be));
      check_val("mem_writedata",  64'(mem_writedata),  64'(wd));
    end
    if (!rst && pend_v && pend_own == 0) check_val("m0_readdata", 64'(m0_readdata), 64'(pend_data));
    if (!rst && pend_v && pend_own == 1) check_val("m1_readdata", 64'(m1_readdata), 64'(pend_data));

    if (rst) begin
      pend_v = 0; served_last = 1; err_m = 0;
    end else begin
      pend_v = (win >= 0) && !wr;
      if (win >= 0) begin
        served_last = win;
        pend_own    = win;
        if (oor) begin
          if (err_m < 65535) err_m++;
        end else if (wr) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) model_mem[addr][8*b +: 8] = wd[8*b +: 8];
        end
        pend_data = oor ? 32'h0 : model_mem[addr];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rst);
    step(rst, 0, 0, 16'h0, 4'h0, 32'h0, 0, 0, 16'h0, 4'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) model_mem[i] = init_word(i);
    served_last = 1; pend_v = 0; pend_own = 0; pend_data = '0; err_m = 0;
    reset = 1'b1;
    m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
    @(posedge clk);
    #1;

    // reset state
    repeat (3) idle(1);

    // lone m0 read
    step(0, 1, 0, 16'h0010, 4'hF, 32'h0, 0, 0, 16'h0, 4'h0, 32'h0);
    idle(0);

    // continuous contention straight out of reset
    idle(1);
    for (int k = 0; k < 8; k++)
      step(0, 1, 0, 16'(16'h0030 + k), 4'hF, 32'h0, 1, 0, 16'(16'h0040 + k), 4'hF, 32'h0);
    idle(0);

    // partial byte write then readback by the other master
    step(0, 0, 0, 16'h0, 4'h0, 32'h0, 0, 1, 16'h0100, 4'b0011, 32'hCAFEBABE);
    step(0, 1, 0, 16'h0100, 4'hF, 32'h0, 0, 0, 16'h0, 4'h0, 32'h0);
    idle(0);

    // out-of-range write then read
    idle(1);
    step(0, 0, 1, 16'd40000, 4'hF, 32'hDEADBEEF, 0, 0, 16'h0, 4'h0, 32'h0);
    step(0, 0, 0, 16'h0, 4'h0, 32'h0, 1, 0, 16'hFFFF, 4'hF, 32'h0);
    idle(0);
    check_val("err_after_two_oor", 64'(err_count), 64'd2);

    // read in flight when reset arrives, then contention after release
    step(0, 1, 0, 16'h0005, 4'hF, 32'h0, 0, 0, 16'h0, 4'h0, 32'h0);
    idle(1);
    idle(1);
    step(0, 1, 0, 16'h0006, 4'hF, 32'h0, 1, 0, 16'h0007, 4'hF, 32'h0);
    step(0, 1, 0, 16'h0006, 4'hF, 32'h0, 1, 0, 16'h0007, 4'hF, 32'h0);
    idle(0);

    // read and write together: write only
    step(0, 1, 1, 16'h0020, 4'hF, 32'h12345678, 0, 0, 16'h0, 4'h0, 32'h0);
    idle(0);
    step(0, 0, 0, 16'h0, 4'h0, 32'h0, 1, 0, 16'h0020, 4'hF, 32'h0);
    idle(0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      bit          rs, r0, w0, r1, w1;
      logic [15:0] a0, a1;
      rs = ($urandom_range(0, 99) == 0);
      r0 = $urandom_range(0, 1); w0 = ($urandom_range(0, 3) == 0);
      r1 = $urandom_range(0, 1); w1 = ($urandom_range(0, 3) == 0);
      a0 = ($urandom_range(0, 9) == 0) ? 16'(40000 + $urandom_range(0, 25535)) : 16'($urandom_range(0, 63));
      a1 = ($urandom_range(0, 9) == 0) ? 16'(40000 + $urandom_range(0, 25535)) : 16'($urandom_range(0, 63));
      step(rs, r0, w0, a0, 4'($urandom), $urandom, r1, w1, a1, 4'($urandom), $urandom);
    end
    idle(0);

    // saturate the error counter with a stream of out-of-range writes
    reset = 0;
    m0_read = 0; m0_write = 1; m0_address = 16'hFFFF; m0_byteenable = 4'hF; m0_writedata = 32'h0;
    m1_read = 0; m1_write = 0;
    repeat (65540) @(posedge clk);
    #1;
    err_m       = (err_m + 65540 > 65535) ? 65535 : err_m + 65540;
    served_last = 0;
    pend_v      = 0;
    idle(0);
    check_val("err_saturated", 64'(err_count), 64'hFFFF);
    step(0, 0, 1, 16'd50000, 4'hF, 32'h0, 0, 0, 16'h0, 4'h0, 32'h0);
    idle(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/audio_nios_onchip_memory2_arbiter.md
# audio_nios_onchip_memory2_arbiter

Two-master arbiter sharing the single-port 40000×32 on-chip program/data RAM between the Nios II data master (m0) and the audio sample DMA (m1). It presents one Avalon-MM slave port per master with waitrequest/readdatavalid, issues at most one access per cycle to the RAM using round-robin arbitration, and returns read data to the correct owner. Out-of-range accesses are blocked and counted.

## Interface
- ADDR_W, 16, word address width (both masters and RAM)
- DATA_W, 32, data width
- BE_W, 4, byteenable width (DATA_W/8)
- DEPTH, 40000, number of valid words; addresses ≥ DEPTH are out of range
- ERR_W, 16, width of the out-of-range error counter
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- m0_address / m1_address  in  ADDR_W  word address
- m0_byteenable / m1_byteenable  in  BE_W  byte lanes for writes
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_waitrequest / m1_waitrequest  out  1  command not accepted this cycle; master holds it
- m0_readdata / m1_readdata  out  DATA_W  read data, valid with readdatavalid
- m0_readdatavalid / m1_readdatavalid  out  1  one-cycle read-data strobe
- mem_address  out  ADDR_W  to RAM address port
- mem_byteenable  out  BE_W  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_clken  out  1  RAM clock enable
- mem_readdata  in  DATA_W  RAM output (address registered, output unregistered: 1-cycle latency)
- err_count  out  ERR_W  saturating count of out-of-range accesses

## Operation
- Request from mN: mN_read | mN_write. If both asserted, treated as write (read ignored).
- Arbitration each cycle: one requester → it wins; both → the master not granted last (rr pointer `last`) wins. `last` updates only on an accepted command.
- Winner: waitrequest=0, command accepted this cycle; loser: waitrequest=1. Idle master: waitrequest=0 (Avalon idle state; no effect).
- Accepted in-range command drives mem_chipselect=1, mem_write=write, and address/byteenable/writedata from winner the same cycle. No accepted command: mem_chipselect=0, mem_write=0.
- Accepted read: tag register {valid, owner, oor} set; next cycle mN_readdatavalid=1 for owner, mN_readdata=mem_readdata (0 if oor). Non-owner readdatavalid=0. Both readdata buses may carry mem_readdata; only valid strobe is meaningful.
- Out-of-range (address ≥ DEPTH): accepted (no stall), mem_chipselect=0, write dropped, read returns 0 with normal readdatavalid timing; err_count += 1, saturating at all-ones.
- mem_clken = ~reset.
- Reset (sync): `last`=m1 (so m0 wins first contention), tag cleared, err_count=0, both waitrequest=1, both readdatavalid=0, mem_chipselect=0, mem_write=0, mem_clken=0. Reset asserted while a read is in flight: its readdatavalid is suppressed.

## Timing
- Command acceptance: 0 cycles of arbitration latency (combinational grant from registered `last`).
- Read latency: exactly 1 cycle from accept to readdatavalid; back-to-back reads sustain 1 access/cycle, alternating owners under contention.
- Write completes in the accept cycle; a read of the same address accepted next cycle returns the new data.
- Max wait for a continuously requesting master under full contention: 1 cycle.
- Outputs to RAM and waitrequest are combinational from inputs + registers; readdatavalid and tag are registered.

## Structure
- Shared package audio_nios_mem_pkg: ADDR_W/DATA_W/BE_W/DEPTH constants, owner encoding (OWN_M0=0, OWN_M1=1), tag struct {valid, owner, oor}.
- One natural sub-module: audio_nios_rr_arb2 (2-way round-robin arbiter: req[1:0], accept, grant[1:0], last register). Datapath mux, tag pipe, error counter stay in top.

## Test plan
- Reset then m0 read 0x0010 alone -> m0_waitrequest=0 same cycle, mem_chipselect=1, m0_readdatavalid=1 next cycle with RAM word at 0x0010; m1 strobes stay 0.
- m0 and m1 both read continuously from cycle 0 after reset -> grants m0,m1,m0,m1…; each readdatavalid one cycle after its accept; each master waits ≤1 cycle.
- m1 write 0xCAFEBABE, byteenable 4'b0011 to 0x0100, then m0 read 0x0100 -> returns {old[31:16],16'hBABE}.
- m0 write to 40000 then m1 read 65535 -> no mem_chipselect either cycle, RAM unchanged, m1 readdata=0 with readdatavalid, err_count=2; force 65535+ errors -> err_count holds 0xFFFF.
- Read accepted then reset asserted next cycle -> no readdatavalid; during reset waitrequest=1 both, mem_chipselect=0, mem_clken=0; after release first contention goes to m0.
- m0 asserts read and write together to 0x0020 -> treated as write only, no readdatavalid.
